// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: counter encodings, counter update rule
// and the PHT controller state encoding.
package bpu_pkg;

    localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not-taken (post-clear value)
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } pht_state_e;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == ST) res = ST;
            else           res = ctr + 2'b01;
        end else begin
            if (ctr == SNT) res = SNT;
            else            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/gshare_pht_if.sv
// Fetch-side lookup and resolution-side update bundle of the gshare predictor.
interface gshare_pht_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int GHR_WIDTH  = 8
);
    logic                  stall;
    logic                  pred_valid;
    logic [31:0]           pred_pc;
    logic                  pred_ready;
    logic                  pred_resp_valid;
    logic                  pred_taken;
    logic [1:0]            pred_ctr;
    logic [ADDR_WIDTH-1:0] pred_idx;
    logic [GHR_WIDTH-1:0]  pred_ghr;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_idx;
    logic [1:0]            upd_ctr;
    logic                  upd_taken;
    logic                  upd_mispredict;
    logic [GHR_WIDTH-1:0]  upd_ghr;

    // Fetch / resolve logic side.
    modport master (
        output stall, pred_valid, pred_pc,
        output upd_valid, upd_idx, upd_ctr, upd_taken, upd_mispredict, upd_ghr,
        input  pred_ready, pred_resp_valid, pred_taken, pred_ctr, pred_idx, pred_ghr
    );

    // Predictor side.
    modport slave (
        input  stall, pred_valid, pred_pc,
        input  upd_valid, upd_idx, upd_ctr, upd_taken, upd_mispredict, upd_ghr,
        output pred_ready, pred_resp_valid, pred_taken, pred_ctr, pred_idx, pred_ghr
    );
endinterface

// File: rtl/sp_bram.sv
// Block RAM with one write port and one registered read port. A read and a
// write to the same address in one cycle return the old contents; the caller
// handles forwarding. Only the read register is reset; the array is not.
module sp_bram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] mem_r [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] doutb_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wea) mem_r[addra] <= dina;
    end

    // Read port; output holds when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      doutb_r <= '0;
        else if (enb) doutb_r <= mem_r[addrb];
    end

    assign doutb = doutb_r;

endmodule

// File: rtl/gshare_pht.sv
// Gshare direction predictor: PC xor global history indexes a 2-bit counter
// table. Lookups answer one cycle later; resolved branches write the stepped
// counter back and repair the history on a mispredict. After reset the table
// is swept to weakly-not-taken before lookups are accepted.
module gshare_pht
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int GHR_WIDTH  = 8,
    parameter int PC_LSB     = 2
) (
    input  logic       clk,
    input  logic       rst,
    gshare_pht_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CLR_STEP = ADDR_WIDTH'(1);

    // Shift one outcome into the history, dropping the oldest bit.
    function automatic logic [GHR_WIDTH-1:0] ghr_shift(input logic [GHR_WIDTH-1:0] hist,
                                                       input logic bit_in);
        logic [GHR_WIDTH-1:0] res;
        res    = hist << 1'b1;
        res[0] = bit_in;
        return res;
    endfunction

    // History zero-extended to index width, occupying the low bits.
    function automatic logic [ADDR_WIDTH-1:0] ghr_ext(input logic [GHR_WIDTH-1:0] hist);
        logic [ADDR_WIDTH-1:0] res;
        res                 = '0;
        res[GHR_WIDTH-1:0]  = hist;
        return res;
    endfunction

    pht_state_e            state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] clr_cnt_r, clr_cnt_next_s;
    logic                  ready_r;
    logic [GHR_WIDTH-1:0]  ghr_r, ghr_next_s;
    logic                  shift_pend_r, shift_pend_next_s;

    logic                  run_s, accept_s, upd_wr_s, repair_s;
    logic [ADDR_WIDTH-1:0] hash_idx_s;
    logic [1:0]            upd_data_s;

    logic                  bram_we_s;
    logic [ADDR_WIDTH-1:0] bram_waddr_s;
    logic [1:0]            bram_wdata_s;
    logic [1:0]            bram_rdata_s;

    logic                  resp_valid_r;
    logic [ADDR_WIDTH-1:0] resp_idx_r;
    logic [GHR_WIDTH-1:0]  resp_ghr_r;
    logic                  byp_hit_r;
    logic [1:0]            byp_data_r;
    logic [1:0]            resp_ctr_s;
    logic                  pc_unused_s;

    assign run_s      = (state_r == RUN);
    assign accept_s   = bus.pred_valid & ready_r & ~bus.stall;
    assign upd_wr_s   = run_s & bus.upd_valid;
    assign repair_s   = upd_wr_s & bus.upd_mispredict;
    assign hash_idx_s = bus.pred_pc[PC_LSB +: ADDR_WIDTH] ^ ghr_ext(ghr_r);
    assign upd_data_s = ctr_next(bus.upd_ctr, bus.upd_taken);
    assign pc_unused_s = ^{bus.pred_pc, bus.upd_ghr};

    // Controller state, sweep pointer and ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= CLEAR;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
            ready_r   <= (state_next_s == RUN);
        end
    end

    // Sweep sequencing: terminal compare on the last entry, pointer wraps to 0.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        case (state_r)
            CLEAR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    state_next_s   = RUN;
                    clr_cnt_next_s = '0;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + CLR_STEP;
                end
            end
            RUN: begin
                state_next_s = RUN;
            end
            default: begin
                state_next_s   = CLEAR;
                clr_cnt_next_s = '0;
            end
        endcase
    end

    // Table write port is owned by the sweep while clearing, by updates after.
    always_comb begin
        bram_we_s    = 1'b0;
        bram_waddr_s = bus.upd_idx;
        bram_wdata_s = upd_data_s;
        case (state_r)
            CLEAR: begin
                bram_we_s    = 1'b1;
                bram_waddr_s = clr_cnt_r;
                bram_wdata_s = WNT;
            end
            RUN: begin
                bram_we_s    = bus.upd_valid;
                bram_waddr_s = bus.upd_idx;
                bram_wdata_s = upd_data_s;
            end
            default: begin
                bram_we_s    = 1'b0;
            end
        endcase
    end

    // History: repair wins; otherwise the pending prediction is shifted in on
    // the first unstalled cycle after its lookup, and a stall freezes it.
    always_comb begin
        ghr_next_s        = ghr_r;
        shift_pend_next_s = shift_pend_r;
        if (repair_s) begin
            ghr_next_s        = ghr_shift(bus.upd_ghr, bus.upd_taken);
            shift_pend_next_s = 1'b0;
        end else if (bus.stall) begin
            ghr_next_s        = ghr_r;
            shift_pend_next_s = shift_pend_r;
        end else begin
            if (shift_pend_r) ghr_next_s = ghr_shift(ghr_r, resp_ctr_s[1]);
            else              ghr_next_s = ghr_r;
            shift_pend_next_s = accept_s;
        end
    end

    // History registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r        <= '0;
            shift_pend_r <= 1'b0;
        end else begin
            ghr_r        <= ghr_next_s;
            shift_pend_r <= shift_pend_next_s;
        end
    end

    // Response pipeline and same-cycle write forwarding, captured on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_idx_r   <= '0;
            resp_ghr_r   <= '0;
            byp_hit_r    <= 1'b0;
            byp_data_r   <= '0;
        end else begin
            if (!bus.stall) resp_valid_r <= accept_s;
            if (accept_s) begin
                resp_idx_r <= hash_idx_s;
                resp_ghr_r <= ghr_r;
                byp_hit_r  <= upd_wr_s && (bus.upd_idx == hash_idx_s);
                byp_data_r <= upd_data_s;
            end
        end
    end

    // Counter returned: forwarded write data, else the table read.
    always_comb begin
        resp_ctr_s = bram_rdata_s;
        if (byp_hit_r) resp_ctr_s = byp_data_r;
        else           resp_ctr_s = bram_rdata_s;
    end

    sp_bram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (2)
    ) u_pht (
        .clk   (clk),
        .rst   (rst),
        .wea   (bram_we_s),
        .addra (bram_waddr_s),
        .dina  (bram_wdata_s),
        .enb   (accept_s),
        .addrb (hash_idx_s),
        .doutb (bram_rdata_s)
    );

    assign bus.pred_ready      = ready_r;
    assign bus.pred_resp_valid = resp_valid_r;
    assign bus.pred_taken      = resp_ctr_s[1];
    assign bus.pred_ctr        = resp_ctr_s;
    assign bus.pred_idx        = resp_idx_r;
    assign bus.pred_ghr        = resp_ghr_r;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with hand-computed expectations.
// Response tuple compared as {valid, taken, ctr[1:0], idx[7:0], ghr[7:0]}.
module tb_gshare_pht;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   cyc;
    logic [19:0] exp_v;
    logic [19:0] resp_v;

    gshare_pht_if #(.ADDR_WIDTH(8), .GHR_WIDTH(8)) bus ();

    gshare_pht #(.ADDR_WIDTH(8), .GHR_WIDTH(8), .PC_LSB(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign resp_v = {bus.pred_resp_valid, bus.pred_taken, bus.pred_ctr, bus.pred_idx, bus.pred_ghr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall          = 1'b0;
        bus.pred_valid     = 1'b0;
        bus.pred_pc        = 32'h0;
        bus.upd_valid      = 1'b0;
        bus.upd_idx        = 8'h00;
        bus.upd_ctr        = 2'b00;
        bus.upd_taken      = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.upd_ghr        = 8'h00;
    endtask

    task automatic set_upd(input logic [7:0] idx, input logic [1:0] ctr, input logic tk,
                           input logic mis, input logic [7:0] g);
        bus.upd_valid      = 1'b1;
        bus.upd_idx        = idx;
        bus.upd_ctr        = ctr;
        bus.upd_taken      = tk;
        bus.upd_mispredict = mis;
        bus.upd_ghr        = g;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = pc;
        step();
        bus.pred_valid = 1'b0;
    endtask

    // Mispredict repair to a scratch entry forces the history to zero.
    task automatic reset_ghr();
        set_upd(8'hFE, 2'b01, 1'b0, 1'b1, 8'h00);
        step();
        idle_inputs();
    endtask

    // Run the post-reset sweep, optionally poking lookups/updates that must be ignored.
    task automatic sweep(input bit inject, output int n);
        n = 0;
        while (bus.pred_ready !== 1'b1 && n < 400) begin
            if (inject) begin
                bus.pred_valid = 1'b1;
                bus.pred_pc    = 32'h40;
                if (n == 200) set_upd(8'h00, 2'b01, 1'b1, 1'b1, 8'h55);
                else          bus.upd_valid = 1'b0;
            end
            step();
            n++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step(); step(); step();
        total++; if (bus.pred_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", bus.pred_ready); else passed++;
        exp_v = 20'h0;
        total++; if (resp_v !== exp_v) $display("FAIL reset_resp got %h exp %h", resp_v, exp_v); else passed++;
        rst = 1'b0;
        sweep(1'b0, cyc);
        total++; if (cyc != 256) $display("FAIL clear_len got %0d exp 256", cyc); else passed++;
    endtask

    task automatic test_clear_values();
        lookup(32'h0000_0000);
        exp_v = {1'b1, 1'b0, 2'b01, 8'h00, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL clear_pc0 got %h exp %h", resp_v, exp_v); else passed++;
        step();
        total++; if (bus.pred_resp_valid !== 1'b0) $display("FAIL valid_drop got %b exp 0", bus.pred_resp_valid); else passed++;
        lookup(32'h0000_03FC);
        exp_v = {1'b1, 1'b0, 2'b01, 8'hFF, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL clear_pcff got %h exp %h", resp_v, exp_v); else passed++;
        step();
    endtask

    task automatic test_update_sat();
        set_upd(8'h10, 2'b01, 1'b1, 1'b0, 8'h00);
        step();
        idle_inputs();
        lookup(32'h0000_0040);
        exp_v = {1'b1, 1'b1, 2'b10, 8'h10, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL upd_01_to_10 got %h exp %h", resp_v, exp_v); else passed++;
        step();
        set_upd(8'h10, 2'b10, 1'b1, 1'b0, 8'h00); step();
        set_upd(8'h10, 2'b11, 1'b1, 1'b0, 8'h00); step();
        set_upd(8'h10, 2'b11, 1'b1, 1'b0, 8'h00); step();
        idle_inputs();
        reset_ghr();
        lookup(32'h0000_0040);
        exp_v = {1'b1, 1'b1, 2'b11, 8'h10, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL upd_sat_hi got %h exp %h", resp_v, exp_v); else passed++;
        step();
    endtask

    task automatic test_spec_ghr();
        lookup(32'h0000_0040);
        exp_v = {1'b1, 1'b0, 2'b01, 8'h11, 8'h01};
        total++; if (resp_v !== exp_v) $display("FAIL spec_shift got %h exp %h", resp_v, exp_v); else passed++;
        step();
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h0000_0040;
        set_upd(8'h20, 2'b01, 1'b0, 1'b1, 8'hA5);
        step();
        idle_inputs();
        exp_v = {1'b1, 1'b0, 2'b01, 8'h12, 8'h02};
        total++; if (resp_v !== exp_v) $display("FAIL repair_acc got %h exp %h", resp_v, exp_v); else passed++;
        step();
        lookup(32'h0000_0000);
        exp_v = {1'b1, 1'b0, 2'b01, 8'h4A, 8'h4A};
        total++; if (resp_v !== exp_v) $display("FAIL repair_ghr got %h exp %h", resp_v, exp_v); else passed++;
        step();
        reset_ghr();
        lookup(32'h0000_0080);
        exp_v = {1'b1, 1'b0, 2'b00, 8'h20, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL upd_01_to_00 got %h exp %h", resp_v, exp_v); else passed++;
        step();
        set_upd(8'h20, 2'b00, 1'b0, 1'b0, 8'h00);
        step();
        idle_inputs();
        lookup(32'h0000_0080);
        exp_v = {1'b1, 1'b0, 2'b00, 8'h20, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL upd_sat_lo got %h exp %h", resp_v, exp_v); else passed++;
        step();
    endtask

    task automatic test_bypass();
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h0000_00C0;
        set_upd(8'h30, 2'b01, 1'b1, 1'b0, 8'h00);
        step();
        idle_inputs();
        exp_v = {1'b1, 1'b1, 2'b10, 8'h30, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL bypass_hit got %h exp %h", resp_v, exp_v); else passed++;
        step();
        reset_ghr();
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h0000_00C0;
        set_upd(8'h31, 2'b01, 1'b0, 1'b0, 8'h00);
        step();
        idle_inputs();
        exp_v = {1'b1, 1'b1, 2'b10, 8'h30, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL bypass_miss got %h exp %h", resp_v, exp_v); else passed++;
        step();
        reset_ghr();
    endtask

    task automatic test_stall();
        lookup(32'h0000_0040);
        bus.stall      = 1'b1;
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h0000_0000;
        set_upd(8'h10, 2'b11, 1'b0, 1'b0, 8'h00);
        exp_v = {1'b1, 1'b1, 2'b11, 8'h10, 8'h00};
        for (int i = 0; i < 3; i++) begin
            step();
            bus.upd_valid = 1'b0;
            total++; if (resp_v !== exp_v) $display("FAIL stall_hold%0d got %h exp %h", i, resp_v, exp_v); else passed++;
        end
        idle_inputs();
        step();
        total++; if (bus.pred_resp_valid !== 1'b0) $display("FAIL stall_release got %b exp 0", bus.pred_resp_valid); else passed++;
        lookup(32'h0000_0040);
        exp_v = {1'b1, 1'b0, 2'b01, 8'h11, 8'h01};
        total++; if (resp_v !== exp_v) $display("FAIL stall_ghr got %h exp %h", resp_v, exp_v); else passed++;
        step();
        reset_ghr();
        lookup(32'h0000_0040);
        exp_v = {1'b1, 1'b1, 2'b10, 8'h10, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL stall_upd got %h exp %h", resp_v, exp_v); else passed++;
        step();
        reset_ghr();
    endtask

    task automatic test_back_to_back();
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h0000_0040;
        step();
        exp_v = {1'b1, 1'b1, 2'b10, 8'h10, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL b2b_first got %h exp %h", resp_v, exp_v); else passed++;
        bus.pred_pc = 32'h0000_0000;
        set_upd(8'h50, 2'b01, 1'b1, 1'b0, 8'h00);
        step();
        idle_inputs();
        exp_v = {1'b1, 1'b0, 2'b01, 8'h00, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL b2b_second got %h exp %h", resp_v, exp_v); else passed++;
        step();
        lookup(32'h0000_0000);
        exp_v = {1'b1, 1'b0, 2'b01, 8'h02, 8'h02};
        total++; if (resp_v !== exp_v) $display("FAIL b2b_ghr got %h exp %h", resp_v, exp_v); else passed++;
        step();
        reset_ghr();
    endtask

    task automatic test_reset_mid();
        lookup(32'h0000_0040);
        #1 rst = 1'b1;
        #1;
        exp_v = 20'h0;
        total++; if (resp_v !== exp_v) $display("FAIL run_rst_resp got %h exp %h", resp_v, exp_v); else passed++;
        total++; if (bus.pred_ready !== 1'b0) $display("FAIL run_rst_ready got %b exp 0", bus.pred_ready); else passed++;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        total++; if (bus.pred_ready !== 1'b0) $display("FAIL mid_clear_ready got %b exp 0", bus.pred_ready); else passed++;
        rst = 1'b1;
        #1;
        total++; if (resp_v !== exp_v) $display("FAIL clr_rst_resp got %h exp %h", resp_v, exp_v); else passed++;
        step();
        rst = 1'b0;
        sweep(1'b1, cyc);
        total++; if (cyc != 256) $display("FAIL reclear_len got %0d exp 256", cyc); else passed++;
        total++; if (bus.pred_resp_valid !== 1'b0) $display("FAIL clear_ignores_lookup got %b exp 0", bus.pred_resp_valid); else passed++;
        lookup(32'h0000_0040);
        exp_v = {1'b1, 1'b0, 2'b01, 8'h10, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL reclear_entry got %h exp %h", resp_v, exp_v); else passed++;
        step();
        lookup(32'h0000_0000);
        exp_v = {1'b1, 1'b0, 2'b01, 8'h00, 8'h00};
        total++; if (resp_v !== exp_v) $display("FAIL clear_ignores_upd got %h exp %h", resp_v, exp_v); else passed++;
        step();
    endtask

    // Test sequence.
    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_clear_values();
        test_update_sat();
        test_spec_ghr();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gshare_pht.md
# gshare_pht

Gshare direction predictor front end for the fetch stage. It hashes the fetch PC with a global history register (GHR), reads a 2-bit saturating-counter pattern history table held in an `sp_bram` instance (DATA_WIDTH=2), and returns taken/not-taken one cycle later. On branch resolution it writes back the updated counter and repairs the GHR. After reset it clears the table with a sweep state machine.

## Interface
- ADDR_WIDTH, 8, PHT index width (2^ADDR_WIDTH entries)
- GHR_WIDTH, 8, history length; must be 1..ADDR_WIDTH
- PC_LSB, 2, lowest PC bit used in the hash
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  fetch hold; blocks new lookups and freezes response outputs
- pred_valid  in  1  lookup request
- pred_pc  in  32  fetch PC
- pred_ready  out  1  0 while clearing, 1 in RUN
- pred_resp_valid  out  1  response valid
- pred_taken  out  1  predicted direction (counter MSB)
- pred_ctr  out  2  counter value read
- pred_idx  out  ADDR_WIDTH  index used; carried down the pipe
- pred_ghr  out  GHR_WIDTH  GHR used for the hash; carried down the pipe
- upd_valid  in  1  resolved branch
- upd_idx  in  ADDR_WIDTH  index from the lookup
- upd_ctr  in  2  counter from the lookup
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  direction mispredicted; repair GHR
- upd_ghr  in  GHR_WIDTH  GHR from the lookup

## Operation
- States: CLEAR and RUN. Reset enters CLEAR with clr_cnt=0.
- CLEAR: each cycle write 2'b01 (weakly not-taken) to `clr_cnt`, then increment. After entry 2^ADDR_WIDTH-1 is written, go to RUN. pred_ready=0. Lookups and updates are ignored, and the GHR is not modified.
- Accept condition: pred_valid & pred_ready & !stall. This drives the BRAM `enb`.
- Hash: idx = pred_pc[PC_LSB +: ADDR_WIDTH] ^ zero-extended ghr (GHR occupies the low bits).
- Speculative history: on accept, ghr <= {ghr[GHR_WIDTH-2:0], predicted}. The predicted bit is not known until N+1, so the shift is applied at N+1 using the BRAM output (or bypass).
- Update, when upd_valid in RUN:
  - write ctr_next(upd_ctr, upd_taken) to upd_idx;
  - saturating: taken → min(ctr+1, 3); not taken → max(ctr-1, 0);
  - the write is issued even if the value is unchanged.
- Repair: on upd_valid & upd_mispredict, ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}. This overrides any speculative shift in the same cycle.
- Write-read bypass: if a write (update) and an accepted lookup hit the same index in the same cycle, the response returns the written value, not the stale BRAM data. The bypass compare and data are registered.
- Under stall, the response outputs and GHR hold. Updates still proceed. A held pred_ctr may therefore be stale; this is accepted.

## Timing
- Lookup latency is 1 cycle: accept at N gives pred_resp_valid=1 at N+1 with taken, ctr, idx and ghr.
- pred_resp_valid is 1 at N+1 iff accepted at N; it holds its value while stall=1.
- An update write lands in the RAM at the next edge. A lookup of the same index one cycle later reads the new value.
- Clear takes exactly 2^ADDR_WIDTH cycles after reset deassertion; pred_ready rises on the next cycle.
- Reset values: pred_ready 0, pred_resp_valid 0, pred_taken 0, pred_ctr 0, pred_idx 0, pred_ghr 0, internal ghr 0, clr_cnt 0, state CLEAR.
- Reset asserted mid-operation or mid-clear aborts everything and restarts the sweep from entry 0.
- clr_cnt wraps cleanly: a terminal compare ends the sweep with no overflow write.

## Structure
- Shared package `bpu_pkg`:
  - counter constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - function ctr_next;
  - state enum {CLEAR, RUN}.
- Sub-module: one `sp_bram` instance u_pht (ADDR_WIDTH, DATA_WIDTH=2). Its write port is muxed between the clear sweep and updates.
- Everything else (hash, GHR, FSM, bypass) lives in gshare_pht itself.

## Test plan
- Reset, then hold 256 cycles → pred_ready=0 throughout, 1 on cycle 257. Every lookup then returns ctr=01, taken=0.
- GHR=0, pc=0x0000_0040, idx=0x10. Issue updates taken with ctr 01, then 10, then 11, then 11 → RAM 10, 11, 11, 11. A lookup returns ctr=11, taken=1.
- Same cycle: update idx 0x10 writes 10 and a lookup hashes to 0x10 → response ctr=10, not the old 01.
- Speculative GHR 0x00 after a taken prediction → 0x01. A mispredict update with upd_ghr=0xA5, taken=0 in the same cycle as an accept → ghr=0x4A.
- Raise stall after an accept → outputs frozen for 3 cycles. An update during the stall still writes. pred_resp_valid stays 1.
- Assert rst during RUN and mid-clear at clr_cnt=100 → outputs return to reset values and the sweep restarts at 0.
